maxpool_relu_l2: RTL and testbench

//  Layer-2 post-processing stage directly downstream of the 3x3 conv layer-2 block.

---
 rtl/maxpool_relu_l2.sv | 123 ++++++++++++
 tb/tb_maxpool_relu_l2.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_relu_l2.sv
// maxpool_relu_l2
//   Post-processing stage that follows the 3x3 conv layer-2 block.
//   It takes a raster-ordered FxF feature map with OCH channels carried in
//   parallel on every beat. It applies 2x2/stride-2 signed max-pooling and
//   then ReLU, and emits an (F/2)x(F/2)xOCH raster stream.
//
// Parameters
//   F   : input feature-map width = height (even)
//   B   : bits per channel sample, signed two's complement
//   OCH : channels per beat
//
// Ports
//   i_clk            : clock, rising edge
//   i_rst            : asynchronous active-low reset
//   i_clear          : synchronous frame realign. Zeroes the counters and
//                      outputs; o_err is kept.
//   i_convloed_data  : OCH*B input beat, channel k at [k*B +: B]
//   i_convloed_valid : per-channel valid. A beat is accepted only when all
//                      bits are set.
//   o_pool_data      : pooled + ReLU sample, channel k at [k*B +: B]
//   o_pool_valid     : single-cycle pulse, o_pool_data is new
//   o_pool_last      : with o_pool_valid on the final output of a frame
//   o_err            : sticky, a partial-valid beat was seen
module maxpool_relu_l2 #(
  parameter int unsigned F   = 14,
  parameter int unsigned B   = 8,
  parameter int unsigned OCH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic [OCH*B-1:0] i_convloed_data,
  input  logic [OCH-1:0]   i_convloed_valid,
  output logic [OCH*B-1:0] o_pool_data,
  output logic             o_pool_valid,
  output logic             o_pool_last,
  output logic             o_err
);

  localparam int unsigned CW = $clog2(F);

  logic [CW-1:0]    col;
  logic [CW-1:0]    row;
  logic [OCH*B-1:0] hold;
  logic [OCH*B-1:0] linebuf [F/2];
  logic [OCH*B-1:0] h;
  logic [OCH*B-1:0] pooled;
  logic             accept;
  logic             partial;
  logic [CW-2:0]    lb_idx;

  assign accept  = (&i_convloed_valid) && !i_clear;
  assign partial = (|i_convloed_valid) && !(&i_convloed_valid);
  // For even F, col>>1 spans exactly the F/2 line-buffer entries.
  assign lb_idx  = col[CW-1:1];

  function automatic logic [B-1:0] smax(input logic signed [B-1:0] a,
                                        input logic signed [B-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [B-1:0] relu(input logic [B-1:0] x);
    return x[B-1] ? '0 : x;
  endfunction

  // Horizontal max of the current pair, then vertical max against the row
  // above and ReLU. The result is used only on odd columns.
  always_comb begin
    h      = '0;
    pooled = '0;
    for (int unsigned k = 0; k < OCH; k++) begin
      h[k*B +: B]      = smax(hold[k*B +: B], i_convloed_data[k*B +: B]);
      pooled[k*B +: B] = relu(smax(linebuf[lb_idx][k*B +: B], h[k*B +: B]));
    end
  end

  // Data storage is not reset. Each entry is written before it is read
  // within a frame.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      if (!col[0]) begin
        hold <= i_convloed_data;
      end else if (!row[0]) begin
        linebuf[lb_idx] <= h;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col          <= '0;
      row          <= '0;
      o_pool_data  <= '0;
      o_pool_valid <= 1'b0;
      o_pool_last  <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_pool_valid <= 1'b0;
      o_pool_last  <= 1'b0;
      if (partial) begin
        o_err <= 1'b1;
      end
      if (i_clear) begin
        col         <= '0;
        row         <= '0;
        o_pool_data <= '0;
      end else if (accept) begin
        if (col == CW'(F-1)) begin
          col <= '0;
          row <= (row == CW'(F-1)) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (row[0] && col[0]) begin
          o_pool_data  <= pooled;
          o_pool_valid <= 1'b1;
          o_pool_last  <= (row == CW'(F-1)) && (col == CW'(F-1));
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_relu_l2.sv
module tb_maxpool_relu_l2;

  localparam int F   = 14;
  localparam int B   = 8;
  localparam int OCH = 32;
  localparam int W   = OCH*B;
  localparam int NO  = (F/2)*(F/2);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear = 1'b0;
  logic [W-1:0]   din = '0;
  logic [OCH-1:0] vin = '0;
  logic [W-1:0]   o_pool_data;
  logic           o_pool_valid;
  logic           o_pool_last;
  logic           o_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] got_d [$];
  logic         got_l [$];

  maxpool_relu_l2 #(.F(F), .B(B), .OCH(OCH)) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_clear         (clear),
    .i_convloed_data (din),
    .i_convloed_valid(vin),
    .o_pool_data     (o_pool_data),
    .o_pool_valid    (o_pool_valid),
    .o_pool_last     (o_pool_last),
    .o_err           (o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && o_pool_valid) begin
      got_d.push_back(o_pool_data);
      got_l.push_back(o_pool_last);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: inputs are applied at negedge, and the caller samples 1 unit after posedge.
  task automatic drive_beat(input logic [W-1:0] d, input logic [OCH-1:0] v, input logic clr);
    @(negedge clk);
    din = d; vin = v; clear = clr;
    @(posedge clk);
    #1;
    vin = '0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_beat('0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] bcast(input int v);
    logic [W-1:0] d;
    d = '0;
    for (int k = 0; k < OCH; k++) d[k*B +: B] = B'(v);
    return d;
  endfunction

  // kind 0: ramp, 1: -5 with one 127 spike on ch3, 2: constant 100
  function automatic logic [W-1:0] pix(input int kind, input int r, input int c);
    logic [W-1:0] d;
    int v;
    d = '0;
    for (int k = 0; k < OCH; k++) begin
      case (kind)
        0:       v = r*F + c - 100 + k;
        1:       v = (k == 3 && r == 5 && c == 9) ? 127 : -5;
        default: v = 100;
      endcase
      d[k*B +: B] = B'(v);
    end
    return d;
  endfunction

  function automatic logic [W-1:0] exp_out(input int kind, input int i, input int j);
    logic [W-1:0] d;
    int v;
    d = '0;
    for (int k = 0; k < OCH; k++) begin
      if (kind == 0) begin
        v = (2*i+1)*F + 2*j + 1 - 100 + k;
        if (v < 0) v = 0;
      end else begin
        v = (k == 3 && i == 2 && j == 4) ? 127 : 0;
      end
      d[k*B +: B] = B'(v);
    end
    return d;
  endfunction

  task automatic send_frame(input int kind, input int max_idle, input int drop_idx);
    for (int idx = 0; idx < F*F; idx++) begin
      int r, c;
      r = idx / F; c = idx % F;
      if (idx == drop_idx) begin
        drive_beat(pix(kind, r, c), 32'h0000FFFF, 1'b0);
        chk("partial_no_valid", W'(o_pool_valid), W'(0));
        chk("partial_err", W'(o_err), W'(1));
      end
      drive_beat(pix(kind, r, c), '1, 1'b0);
      chk("valid_latency", W'(o_pool_valid), W'((r % 2 == 1) && (c % 2 == 1)));
      chk("last_flag", W'(o_pool_last), W'((r == F-1) && (c == F-1)));
      if (max_idle > 0) idle($urandom_range(0, max_idle));
    end
  endtask

  task automatic check_outputs(input int kind, input int nframes);
    int n;
    idle(2);
    chk("output_count", W'(got_d.size()), W'(NO*nframes));
    n = (got_d.size() < NO*nframes) ? got_d.size() : NO*nframes;
    for (int o = 0; o < n; o++) begin
      int p;
      p = o % NO;
      chk("pool_data", got_d[o], exp_out(kind, p / (F/2), p % (F/2)));
      chk("pool_last", W'(got_l[o]), W'(p == NO-1));
    end
    got_d.delete();
    got_l.delete();
  endtask

  typedef struct {
    logic [3:0][7:0] a;   // even channels: p(0,0), p(0,1), p(1,0), p(1,1)
    logic [3:0][7:0] b;   // odd channels
    logic [7:0]      ea;
    logic [7:0]      eb;
  } vec_t;

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3, ea, eb);
    vec_t v;
    v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
    v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2); v.b[3] = 8'(b3);
    v.ea = 8'(ea); v.eb = 8'(eb);
    return v;
  endfunction

  initial begin
    vec_t vecs [6];
    vecs[0] = mk(   1,    2,    3,    4,   -1,   -2,   -3,   -4,   4,   0);
    vecs[1] = mk(-128,    0,   -1,   -2,  127, -128,    0,    5,   0, 127);
    vecs[2] = mk(-128,   -1,   -1,   -1,   10,   10,   10,   10,   0,  10);
    vecs[3] = mk(  50,  -50,   60,  -60,   -3,    7,   -7,    3,  60,   7);
    vecs[4] = mk(   0,    0,    0,    0, -128, -128, -128, -128,   0,   0);
    vecs[5] = mk( 100,  127,  126, -128,    1,    0,    0,    0, 127,   1);

    // reset state
    #3;
    chk("rst_data", o_pool_data, '0);
    chk("rst_valid", W'(o_pool_valid), W'(0));
    chk("rst_last", W'(o_pool_last), W'(0));
    chk("rst_err", W'(o_err), W'(0));
    #20 rst_n = 1'b1;

    // single 2x2 windows, realigned with i_clear after each
    for (int v = 0; v < 6; v++) begin
      logic [W-1:0] e;
      e = '0;
      for (int k = 0; k < OCH; k++) e[k*B +: B] = (k % 2 == 0) ? vecs[v].ea : vecs[v].eb;
      for (int idx = 0; idx <= F+1; idx++) begin
        logic [W-1:0] d;
        int p;
        p = (idx == 0) ? 0 : (idx == 1) ? 1 : (idx == F) ? 2 : (idx == F+1) ? 3 : -1;
        d = '0;
        for (int k = 0; k < OCH; k++)
          d[k*B +: B] = (p < 0) ? 8'h80 : (k % 2 == 0) ? vecs[v].a[p] : vecs[v].b[p];
        drive_beat(d, '1, 1'b0);
      end
      chk("win_valid", W'(o_pool_valid), W'(1));
      chk("win_data", o_pool_data, e);
      drive_beat(bcast(77), '1, 1'b1);
      chk("clear_data", o_pool_data, '0);
      chk("clear_valid", W'(o_pool_valid), W'(0));
    end
    idle(1);
    got_d.delete();
    got_l.delete();

    // ramp frame, contiguous
    send_frame(0, 0, -1);
    check_outputs(0, 1);

    // -5 frame with one spike
    send_frame(1, 0, -1);
    check_outputs(1, 1);

    // ramp with random idle gaps
    send_frame(0, 3, -1);
    check_outputs(0, 1);
    chk("err_clean", W'(o_err), W'(0));

    // partial beat at index 20, then resent
    send_frame(0, 0, 20);
    check_outputs(0, 1);
    chk("err_sticky", W'(o_err), W'(1));

    // asynchronous reset mid-frame
    for (int idx = 0; idx < 50; idx++) drive_beat(pix(2, idx / F, idx % F), '1, 1'b0);
    chk("pre_rst_data", o_pool_data, bcast(100));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", o_pool_data, '0);
    chk("async_rst_err", W'(o_err), W'(0));
    #5 rst_n = 1'b1;
    got_d.delete();
    got_l.delete();
    send_frame(0, 0, -1);
    check_outputs(0, 1);

    // i_clear mid-frame with a valid beat
    for (int idx = 0; idx < 50; idx++) drive_beat(pix(2, idx / F, idx % F), '1, 1'b0);
    drive_beat(pix(2, 3, 8), 32'h0000FFFF, 1'b0);
    chk("pre_clear_data", o_pool_data, bcast(100));
    drive_beat(pix(2, 3, 8), '1, 1'b1);
    chk("mid_clear_data", o_pool_data, '0);
    chk("mid_clear_valid", W'(o_pool_valid), W'(0));
    chk("mid_clear_err_kept", W'(o_err), W'(1));
    got_d.delete();
    got_l.delete();
    send_frame(0, 0, -1);
    check_outputs(0, 1);

    // two frames back to back
    send_frame(0, 0, -1);
    send_frame(0, 0, -1);
    check_outputs(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
